switch_input_port: RTL and testbench

//   Input-side counterpart of the LED status path: conditions the four board switches for the CPU.
//   Per switch: synchroniser plus debouncer. Press events are latched into an 8-bit read port.
//   The port is drained by a read strobe and carries a sticky overrun flag.

---
 rtl/switch_io_pkg.sv | 15 +
 rtl/switch_debounce.sv | 59 +++++
 rtl/switch_input_port.sv | 92 +++++++++
 tb/tb_switch_input_port.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/switch_io_pkg.sv
// Shared constants and types for the switch input path.
// Switch count, read-port width, debounce default and read-port states.
package switch_io_pkg;

  localparam int N_SW            = 4;
  localparam int DATA_W          = 8;
  localparam int DEBOUNCE_CYCLES = 250000;
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/switch_debounce.sv
// One switch: 2-flop synchroniser, stability counter, stable level, rise detect.
// Ports: i_Clk, i_Rst_n, i_Raw -> o_Level (debounced), o_Press (1-cycle 0->1 pulse).
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = switch_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Press
);
  import switch_io_pkg::*;

  localparam int CW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q;
  logic          stable_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter only runs while the synchronised input disagrees
  // with the accepted level; any agreement restarts it.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      meta_q   <= i_Raw;
      sync_q   <= meta_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  assign o_Level = stable_q;
  assign o_Press = stable_q & ~prev_q;

endmodule

// File: rtl/switch_input_port.sv
// Debounced switch input port: per-switch conditioning plus a read-port FSM.
// o_Data = {press mask, levels at last event}; o_Valid/o_Overrun cleared by i_Rd.
module switch_input_port #(
  parameter int DEBOUNCE_CYCLES = switch_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst_n,
  input  logic [switch_io_pkg::N_SW-1:0]    i_Switch,
  input  logic                              i_Rd,
  output logic [switch_io_pkg::DATA_W-1:0]  o_Data,
  output logic                              o_Valid,
  output logic                              o_Overrun,
  output logic [switch_io_pkg::N_SW-1:0]    o_Sw_State
);
  import switch_io_pkg::*;

  logic [N_SW-1:0] level;
  logic [N_SW-1:0] press;

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_Clk  (i_Clk),
      .i_Rst_n(i_Rst_n),
      .i_Raw  (i_Switch[g]),
      .o_Level(level[g]),
      .o_Press(press[g])
    );
  end

  rd_state_e       state_q;
  rd_state_e       state_d;
  logic [N_SW-1:0] mask_q;
  logic [N_SW-1:0] mask_d;
  logic [N_SW-1:0] lvl_q;
  logic [N_SW-1:0] lvl_d;
  logic            ovr_q;
  logic            ovr_d;
  logic            any_press;

  assign any_press = |press;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    lvl_d   = lvl_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (any_press) begin
          state_d = PEND;
          mask_d  = press;
          lvl_d   = level;
        end
      end
      PEND: begin
        if (any_press) begin
          // A read in the same cycle consumes the old event,
          // so the new one starts a fresh mask without overrun.
          mask_d = i_Rd ? press : (mask_q | press);
          lvl_d  = level;
          ovr_d  = ~i_Rd;
        end else if (i_Rd) begin
          state_d = IDLE;
          mask_d  = '0;
          ovr_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      lvl_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      lvl_q   <= lvl_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_Data     = {mask_q, lvl_q};
  assign o_Valid    = (state_q == PEND);
  assign o_Overrun  = ovr_q;
  assign o_Sw_State = level;

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with a short debounce window.
// Expected events are queued when switches are driven, popped at output.
module tb_switch_input_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ovr;
  logic [3:0] sws;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       ovr;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;

  switch_input_port #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Switch  (sw),
    .i_Rd      (rd),
    .o_Data    (data),
    .o_Valid   (valid),
    .o_Overrun (ovr),
    .o_Sw_State(sws)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic o);
    ev_t e;
    e.data = d;
    e.ovr  = o;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_data"}, 32'(data), 32'(e.data));
      chk({tag, "_ovr"}, 32'(ovr), 32'(e.ovr));
    end
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    step(1);
    rd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset release, idle
    step(3);
    rst_n = 1'b1;
    step(20);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_sws", 32'(sws), 32'h0);

    // 2: single press, exact latency, then read
    push(8'h11, 1'b0);
    sw = 4'b0001;
    step(5);
    chk("t2_early", 32'(sws), 32'h0);
    step(1);
    chk("t2_lvl", 32'(sws), 32'h1);
    chk("t2_notyet", 32'(valid), 32'd0);
    step(1);
    pop_check("t2_evt");
    rd_pulse();
    chk("t2_rd_valid", 32'(valid), 32'd0);
    chk("t2_rd_data", 32'(data), 32'h01);
    chk("t2_rd_ovr", 32'(ovr), 32'd0);

    // release raises no event; levels in o_Data hold
    sw = 4'b0000;
    step(8);
    chk("rel_sws", 32'(sws), 32'h0);
    chk("rel_valid", 32'(valid), 32'd0);
    chk("rel_data", 32'(data), 32'h01);

    // read while idle is ignored
    rd_pulse();
    step(1);
    chk("idle_rd_valid", 32'(valid), 32'd0);
    chk("idle_rd_data", 32'(data), 32'h01);

    // 3: 3-cycle bounce on switch 2
    sw = 4'b0100;
    step(3);
    sw = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("t3_sws", 32'(sws), 32'h0);
      chk("t3_valid", 32'(valid), 32'd0);
    end

    // 4: two unread presses -> merged mask + overrun
    push(8'h11, 1'b0);
    sw = 4'b0001;
    step(7);
    pop_check("t4_first");
    push(8'h99, 1'b1);
    sw = 4'b1001;
    step(7);
    pop_check("t4_ovr");
    rd_pulse();
    chk("t4_rd_valid", 32'(valid), 32'd0);
    chk("t4_rd_ovr", 32'(ovr), 32'd0);
    chk("t4_rd_data", 32'(data), 32'h09);

    // 5: read coincident with new press while overrun pending
    sw = 4'b0000;
    step(8);
    chk("t5_rel", 32'(sws), 32'h0);
    push(8'h11, 1'b0);
    sw = 4'b0001;
    step(7);
    pop_check("t5_a");
    push(8'h55, 1'b1);
    sw = 4'b0101;
    step(7);
    pop_check("t5_b");
    push(8'h27, 1'b0);
    sw = 4'b0111;
    step(6);
    chk("t5_hold", 32'(data), 32'h55);
    rd_pulse();
    pop_check("t5_rdpress");

    // 6: async reset mid-debounce and mid-pend
    sw = 4'b1111;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_data", 32'(data), 32'h00);
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_ovr", 32'(ovr), 32'd0);
    chk("t6_sws", 32'(sws), 32'h0);
    step(2);
    rst_n = 1'b1;
    push(8'hFF, 1'b0);
    step(5);
    chk("t6_early", 32'(sws), 32'h0);
    step(1);
    chk("t6_lvl", 32'(sws), 32'hF);
    chk("t6_notyet", 32'(valid), 32'd0);
    step(1);
    pop_check("t6_evt");

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
